// File: rtl/tradeoff_pkg.sv
// tradeoff_pkg: shared widths and iteration count for the sqrt engine; TRADEOFF_RADIX4_EN selects two digits per cycle
package tradeoff_pkg;
   localparam int W_BITS = 30;
   localparam int N_BITS = W_BITS / 2 + 2;
   localparam int X_BITS = W_BITS + 2;
   localparam int ROOT_W = 16;
   localparam int REM_W = 18;
`ifdef TRADEOFF_RADIX4_EN
   localparam int DIGITS = 2;
`else
   localparam int DIGITS = 1;
`endif
   localparam int ITER = (W_BITS + 2) / 2 / DIGITS;
   localparam int CNT_W = $clog2(ITER);
endpackage

// File: rtl/sqrt_digit_stage.sv
// sqrt_digit_stage: one restoring square-root digit step producing the next remainder and root bit
module sqrt_digit_stage
   import tradeoff_pkg::*;
(
   input  logic [REM_W-1:0]  rem,
   input  logic [1:0]        pair,
   input  logic [ROOT_W-1:0] root,
   output logic [REM_W-1:0]  rem_nxt,
   output logic              q
);
   logic [REM_W+1:0] r_ext, trial, diff;
   logic unused_hi;
   assign r_ext = {rem, pair};
   assign trial = {2'b00, root, 2'b01};
   assign q = r_ext >= trial;
   assign diff = q ? r_ext - trial : r_ext;
   // remainder stays below 2*root+1, so the top two bits are always zero
   assign rem_nxt = diff[REM_W-1:0];
   assign unused_hi = ^diff[REM_W+1:REM_W];
endmodule

// File: rtl/tradeoff_sqrt16.sv
// tradeoff_sqrt16: iterative floor(sqrt(4*W)) engine that restarts on any W change; TRADEOFF_RADIX4_EN retires two bits per cycle
module tradeoff_sqrt16
   import tradeoff_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [W_BITS-1:0] W,
   output logic [N_BITS-1:0] N,
   output logic              found
);
   logic [W_BITS-1:0] w_reg;
   logic [X_BITS-1:0] x, x_nxt;
   logic [REM_W-1:0]  rem, rem_a, rem_nxt;
   logic [ROOT_W-1:0] root, root_a, root_nxt;
   logic [CNT_W-1:0]  cnt;
   logic              pending, busy, done, q_a, start;

   assign start = pending | (W != w_reg);
   assign found = done & (W == w_reg);

   sqrt_digit_stage u_s0 (.rem(rem), .pair(x[X_BITS-1 -: 2]), .root(root), .rem_nxt(rem_a), .q(q_a));
   assign root_a = {root[ROOT_W-2:0], q_a};

`ifdef TRADEOFF_RADIX4_EN
   logic [REM_W-1:0] rem_b;
   logic             q_b;
   sqrt_digit_stage u_s1 (.rem(rem_a), .pair(x[X_BITS-3 -: 2]), .root(root_a), .rem_nxt(rem_b), .q(q_b));
   assign rem_nxt = rem_b;
   assign root_nxt = {root_a[ROOT_W-2:0], q_b};
   assign x_nxt = {x[X_BITS-5:0], 4'b0000};
`else
   assign rem_nxt = rem_a;
   assign root_nxt = root_a;
   assign x_nxt = {x[X_BITS-3:0], 2'b00};
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         N       <= '0;
         done    <= 1'b0;
         busy    <= 1'b0;
         w_reg   <= '0;
         pending <= 1'b1;
         x       <= '0;
         rem     <= '0;
         root    <= '0;
         cnt     <= '0;
      end else if (start) begin
         w_reg   <= W;
         x       <= {W, 2'b00};
         rem     <= '0;
         root    <= '0;
         cnt     <= '0;
         busy    <= 1'b1;
         done    <= 1'b0;
         N       <= '0;
         pending <= 1'b0;
      end else if (busy) begin
         x    <= x_nxt;
         rem  <= rem_nxt;
         root <= root_nxt;
         cnt  <= cnt + 1'b1;
         if (cnt == CNT_W'(ITER - 1)) begin
            N    <= {{(N_BITS-ROOT_W){1'b0}}, root_nxt};
            busy <= 1'b0;
            done <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_tradeoff_sqrt16.sv
// tb_tradeoff_sqrt16: directed and random checks of tradeoff_sqrt16 against an arithmetic square-root model
module tb_tradeoff_sqrt16;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [29:0] W = '0;
   logic [16:0] N;
   logic        found;
   int          vectors = 0;
   int          miscompares = 0;
   int          lat;
   logic [29:0] w_rand;

`ifdef TRADEOFF_RADIX4_EN
   localparam int LAT = 9;
`else
   localparam int LAT = 17;
`endif

   tradeoff_sqrt16 dut (.clk(clk), .rst_n(rst_n), .W(W), .N(N), .found(found));

   always #5 clk = ~clk;

   function automatic int unsigned ref_root(input logic [29:0] w);
      longint unsigned v = longint'(w) * 4;
      longint unsigned n = 0;
      for (int b = 16; b >= 0; b--) begin
         longint unsigned t = n | (longint'(1) << b);
         if (t * t <= v) n = t;
      end
      return int'(n);
   endfunction

   task automatic check(input string tag, input longint obs, input longint exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wait_found(output int cyc);
      cyc = 0;
      while (cyc < 60) begin
         @(posedge clk);
         #1;
         cyc++;
         if (found) break;
      end
   endtask

   task automatic apply(input logic [29:0] w, input string tag);
      @(negedge clk);
      W = w;
      #1;
      check({tag, "_found_drop"}, found, 0);
      wait_found(lat);
      check({tag, "_latency"}, lat, LAT);
      check({tag, "_N"}, N, ref_root(w));
   endtask

   initial begin
      W = 30'd0;
      #12;
      check("reset_N", N, 0);
      check("reset_found", found, 0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_found(lat);
      check("w0_latency", lat, LAT);
      check("w0_N", N, 0);
      check("w0_found", found, 1);

      apply(30'h3FFF_FFFF, "wmax");
      check("wmax_const", N, 65535);
      apply(30'd1073709056, "w65534");
      check("w65534_const", N, 65534);
      apply(30'd1, "w1");
      check("w1_const", N, 2);
      apply(30'd100, "w100");
      check("w100_const", N, 20);

      repeat (3) @(negedge clk);
      check("hold_N", N, 20);
      check("hold_found", found, 1);
      apply(30'h3FFF_FFFF, "b2b");

      @(negedge clk);
      W = 30'd12345678;
      repeat (8) @(posedge clk);
      @(negedge clk);
      W = 30'd987654321;
      #1;
      check("midchg_found", found, 0);
      wait_found(lat);
      check("midchg_latency", lat, LAT);
      check("midchg_N", N, ref_root(30'd987654321));

      @(negedge clk);
      W = 30'd55555;
      repeat (5) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_mid_N", N, 0);
      check("rst_mid_found", found, 0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_found(lat);
      check("rst_rec_latency", lat, LAT);
      check("rst_rec_N", N, ref_root(30'd55555));

      for (int i = 0; i < 24; i++) begin
         w_rand = 30'($urandom);
         if (w_rand == W) w_rand = w_rand ^ 30'd1;
         apply(w_rand, "rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
